// File: rtl/wb_branch_unit_pkg.sv
// Shared encodings and helpers for the writeback / branch unit.
package wb_branch_unit_pkg;

  localparam int SQUASH_DEPTH_DEF = 2;
  localparam int REG_AW           = 5;

  typedef enum logic [1:0] {
    MD_F    = 2'b00,
    MD_DOUT = 2'b01,
    MD_SLT  = 2'b10,
    MD_F_ALT = 2'b11
  } md_e;

  typedef enum logic [1:0] {
    BS_NEVER = 2'b00,
    BS_COND  = 2'b01,
    BS_BRA   = 2'b10,
    BS_RAA   = 2'b11
  } bs_e;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_BRA = 2'b01,
    PC_RAA = 2'b10,
    PC_RSV = 2'b11
  } pc_sel_e;

  function automatic logic [31:0] wb_select(input logic [1:0]  md,
                                            input logic [31:0] f,
                                            input logic [31:0] dout,
                                            input logic        vxorn);
    logic [31:0] v_sel;
    case (md)
      MD_F:    v_sel = f;
      MD_DOUT: v_sel = dout;
      MD_SLT:  v_sel = {31'b0, vxorn};
      default: v_sel = f;
    endcase
    return v_sel;
  endfunction

endpackage

// File: rtl/wb_branch_unit_if.sv
// Execute/decode-side signal bundle of the writeback / branch unit.
interface wb_branch_unit_if;
  import wb_branch_unit_pkg::*;

  logic              RW;
  logic [REG_AW-1:0] DA;
  logic [1:0]        MD;
  logic [31:0]       F;
  logic [31:0]       Data_Out;
  logic              VxorN;
  logic              BS_one;
  logic              BS_zero;
  logic              PS;
  logic              Z;
  logic [31:0]       BrA;
  logic [31:0]       RAA;
  logic [REG_AW-1:0] AA;
  logic [REG_AW-1:0] BA;
  logic [31:0]       A_DATA;
  logic [31:0]       B_DATA;
  logic [1:0]        PC_SEL;
  logic [31:0]       PC_TARGET;
  logic              FLUSH;

  modport master (
    output RW, DA, MD, F, Data_Out, VxorN, BS_one, BS_zero, PS, Z, BrA, RAA, AA, BA,
    input  A_DATA, B_DATA, PC_SEL, PC_TARGET, FLUSH
  );

  modport slave (
    input  RW, DA, MD, F, Data_Out, VxorN, BS_one, BS_zero, PS, Z, BrA, RAA, AA, BA,
    output A_DATA, B_DATA, PC_SEL, PC_TARGET, FLUSH
  );

endinterface

// File: rtl/wb_branch_unit_reg_file.sv
// NREGS x 32 register file: two combinational read ports with write-through
// bypass, one write port, synchronous reset; R0 is hard zero.
module wb_branch_unit_reg_file
  import wb_branch_unit_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [31:0]       i_wd,
  input  logic [REG_AW-1:0] i_ra_a,
  input  logic [REG_AW-1:0] i_ra_b,
  output logic [31:0]       o_rd_a,
  output logic [31:0]       o_rd_b
);

  logic [31:0] r_mem [NREGS];

  // storage update; index 0 is never written
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (i_rst) begin
        r_mem[i] <= 32'h0;
      end else if (i_we && (i != 0) && (i_wa == REG_AW'(i))) begin
        r_mem[i] <= i_wd;
      end else begin
        r_mem[i] <= r_mem[i];
      end
    end
  end

  // read ports: zero register first, then the pending write, then storage
  always_comb begin
    o_rd_a = 32'h0;
    o_rd_b = 32'h0;
    if (i_ra_a == {REG_AW{1'b0}}) begin
      o_rd_a = 32'h0;
    end else if (i_we && (i_wa == i_ra_a)) begin
      o_rd_a = i_wd;
    end else begin
      o_rd_a = r_mem[i_ra_a];
    end
    if (i_ra_b == {REG_AW{1'b0}}) begin
      o_rd_b = 32'h0;
    end else if (i_we && (i_wa == i_ra_b)) begin
      o_rd_b = i_wd;
    end else begin
      o_rd_b = r_mem[i_ra_b];
    end
  end

endmodule

// File: rtl/wb_branch_unit.sv
// Branch resolution with post-branch squash window, writeback staging register
// and the register file it feeds.
module wb_branch_unit
  import wb_branch_unit_pkg::*;
#(
  parameter int SQUASH_DEPTH = SQUASH_DEPTH_DEF,
  parameter int NREGS        = 32
) (
  input logic             CLOCK,
  input logic             RESET,
  wb_branch_unit_if.slave bus
);

  localparam int CW = $clog2(SQUASH_DEPTH + 1);

  logic [CW-1:0]     r_squash_cnt;
  logic              r_wb_rw;
  logic [REG_AW-1:0] r_wb_da;
  logic [31:0]       r_wb_data;
  logic              w_squashed;
  logic              w_taken;
  pc_sel_e           w_pc_sel;
  logic [31:0]       w_pc_target;

  assign w_squashed = (r_squash_cnt != {CW{1'b0}});

  // branch decision, masked while the current instruction is squashed
  always_comb begin
    w_taken     = 1'b0;
    w_pc_sel    = PC_INC;
    w_pc_target = 32'h0;
    if (!w_squashed) begin
      case (bs_e'({bus.BS_one, bus.BS_zero}))
        BS_NEVER: begin
          w_taken  = 1'b0;
          w_pc_sel = PC_INC;
        end
        BS_COND: begin
          if (bus.Z == bus.PS) begin
            w_taken  = 1'b1;
            w_pc_sel = PC_BRA;
          end else begin
            w_taken  = 1'b0;
            w_pc_sel = PC_INC;
          end
        end
        BS_BRA: begin
          w_taken  = 1'b1;
          w_pc_sel = PC_BRA;
        end
        BS_RAA: begin
          w_taken  = 1'b1;
          w_pc_sel = PC_RAA;
        end
        default: begin
          w_taken  = 1'b0;
          w_pc_sel = PC_INC;
        end
      endcase
    end else begin
      w_taken  = 1'b0;
      w_pc_sel = PC_INC;
    end
    case (w_pc_sel)
      PC_BRA:  w_pc_target = bus.BrA;
      PC_RAA:  w_pc_target = bus.RAA;
      default: w_pc_target = 32'h0;
    endcase
  end

  assign bus.FLUSH     = w_taken;
  assign bus.PC_SEL    = w_pc_sel;
  assign bus.PC_TARGET = w_pc_target;

  // squash window: only an unsquashed taken branch can (re)load it
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_squash_cnt <= {CW{1'b0}};
    end else if (w_taken) begin
      r_squash_cnt <= CW'(SQUASH_DEPTH);
    end else if (w_squashed) begin
      r_squash_cnt <= r_squash_cnt - CW'(1);
    end else begin
      r_squash_cnt <= r_squash_cnt;
    end
  end

  // writeback staging; squashed instructions lose their write enable
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_wb_rw   <= 1'b0;
      r_wb_da   <= {REG_AW{1'b0}};
      r_wb_data <= 32'h0;
    end else begin
      r_wb_rw   <= bus.RW & ~w_squashed;
      r_wb_da   <= bus.DA;
      r_wb_data <= wb_select(bus.MD, bus.F, bus.Data_Out, bus.VxorN);
    end
  end

  wb_branch_unit_reg_file #(
    .NREGS (NREGS)
  ) u_reg_file (
    .i_clk  (CLOCK),
    .i_rst  (RESET),
    .i_we   (r_wb_rw),
    .i_wa   (r_wb_da),
    .i_wd   (r_wb_data),
    .i_ra_a (bus.AA),
    .i_ra_b (bus.BA),
    .o_rd_a (bus.A_DATA),
    .o_rd_b (bus.B_DATA)
  );

endmodule

// File: tb/tb_wb_branch_unit.sv
// Directed bench: expectations are queued as each instruction is driven and
// checked against the combinational outputs just before the next clock edge.
module tb_wb_branch_unit;

  logic CLOCK = 1'b0;
  logic RESET;

  wb_branch_unit_if bus ();

  wb_branch_unit #(
    .SQUASH_DEPTH (2),
    .NREGS        (32)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  typedef enum int { K_FLUSH, K_SEL, K_TGT, K_A, K_B } kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input kind_e k, input logic [31:0] e);
    exp_t x;
    x.tag  = tag;
    x.kind = k;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic exp_pc(input string tag, input logic fl, input logic [1:0] sel,
                        input logic [31:0] tgt);
    push({tag, "_flush"}, K_FLUSH, {31'b0, fl});
    push({tag, "_sel"},   K_SEL,   {30'b0, sel});
    push({tag, "_tgt"},   K_TGT,   tgt);
  endtask

  task automatic idle();
    bus.RW       = 1'b0;
    bus.DA       = 5'd0;
    bus.MD       = 2'b00;
    bus.F        = 32'h0;
    bus.Data_Out = 32'h0;
    bus.VxorN    = 1'b0;
    bus.BS_one   = 1'b0;
    bus.BS_zero  = 1'b0;
    bus.PS       = 1'b0;
    bus.Z        = 1'b0;
    bus.BrA      = 32'h0;
    bus.RAA      = 32'h0;
    bus.AA       = 5'd0;
    bus.BA       = 5'd0;
  endtask

  task automatic wr(input logic [4:0] da, input logic [1:0] md, input logic [31:0] f);
    bus.RW = 1'b1;
    bus.DA = da;
    bus.MD = md;
    bus.F  = f;
  endtask

  task automatic br(input logic [1:0] bs, input logic ps, input logic z,
                    input logic [31:0] bra, input logic [31:0] raa);
    bus.BS_one  = bs[1];
    bus.BS_zero = bs[0];
    bus.PS      = ps;
    bus.Z       = z;
    bus.BrA     = bra;
    bus.RAA     = raa;
  endtask

  // settle, drain the scoreboard against the outputs, then advance one edge
  task automatic cycle();
    exp_t        x;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.kind)
        K_FLUSH: obs = {31'b0, bus.FLUSH};
        K_SEL:   obs = {30'b0, bus.PC_SEL};
        K_TGT:   obs = bus.PC_TARGET;
        K_A:     obs = bus.A_DATA;
        default: obs = bus.B_DATA;
      endcase
      n_assert++;
      assert (obs === x.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      end
    end
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    idle();
    RESET = 1'b1;
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;

    // reset state
    idle(); bus.AA = 5'd5; bus.BA = 5'd31; bus.BrA = 32'h40;
    exp_pc("rst", 1'b0, 2'b00, 32'h0);
    push("rst_a5", K_A, 32'h0); push("rst_b31", K_B, 32'h0);
    cycle();

    // write R5 = 0x1234: invisible at issue, bypassed while pending, then stored
    idle(); wr(5'd5, 2'b00, 32'h1234); bus.AA = 5'd5;
    push("w5_issue_a", K_A, 32'h0);
    cycle();
    idle(); bus.AA = 5'd5; bus.BA = 5'd5;
    push("w5_bypass_a", K_A, 32'h1234); push("w5_bypass_b", K_B, 32'h1234);
    cycle();
    idle(); bus.AA = 5'd5;
    push("w5_stored_a", K_A, 32'h1234);
    cycle();

    // taken conditional branch annuls the next two writes to R3
    idle(); br(2'b01, 1'b1, 1'b1, 32'h40, 32'h80);
    exp_pc("cond_tk", 1'b1, 2'b01, 32'h40);
    cycle();
    idle(); wr(5'd3, 2'b00, 32'hAAAA); br(2'b10, 1'b0, 1'b0, 32'h44, 32'h0);
    exp_pc("sq1", 1'b0, 2'b00, 32'h0);
    cycle();
    idle(); wr(5'd3, 2'b00, 32'hBBBB); bus.AA = 5'd3;
    push("sq2_a3", K_A, 32'h0);
    cycle();
    idle(); wr(5'd3, 2'b00, 32'hCCCC); bus.AA = 5'd3;
    push("sq_done_a3", K_A, 32'h0);
    cycle();
    idle(); bus.AA = 5'd3;
    push("r3_bypass", K_A, 32'hCCCC);
    cycle();
    idle(); bus.AA = 5'd3;
    push("r3_stored", K_A, 32'hCCCC);
    cycle();

    // not-taken conditional: no flush, following write proceeds
    idle(); br(2'b01, 1'b1, 1'b0, 32'h50, 32'h0);
    exp_pc("cond_nt", 1'b0, 2'b00, 32'h0);
    cycle();
    idle(); wr(5'd4, 2'b00, 32'h4444);
    cycle();
    idle(); bus.AA = 5'd4;
    push("r4_bypass", K_A, 32'h4444);
    cycle();

    // taken branch, then a taken jump inside the window must not reload it
    idle(); br(2'b10, 1'b0, 1'b0, 32'h100, 32'h0);
    exp_pc("bra_tk", 1'b1, 2'b01, 32'h100);
    cycle();
    idle(); br(2'b11, 1'b0, 1'b0, 32'h0, 32'h80);
    exp_pc("raa_sq", 1'b0, 2'b00, 32'h0);
    cycle();
    idle(); wr(5'd6, 2'b00, 32'h66);
    cycle();
    idle(); wr(5'd6, 2'b00, 32'h77); br(2'b11, 1'b0, 1'b0, 32'h0, 32'h80);
    exp_pc("raa_tk", 1'b1, 2'b10, 32'h80);
    cycle();
    idle(); bus.AA = 5'd6;
    push("r6_bypass", K_A, 32'h77);
    cycle();
    idle(); bus.AA = 5'd6;
    push("r6_stored", K_A, 32'h77);
    cycle();

    // R0 write ignored; writeback source selects; back-to-back same register
    idle(); wr(5'd0, 2'b00, 32'hFFFF);
    cycle();
    idle(); wr(5'd7, 2'b10, 32'hFFFF); bus.VxorN = 1'b1; bus.AA = 5'd0;
    push("r0_pending", K_A, 32'h0);
    cycle();
    idle(); wr(5'd8, 2'b01, 32'h1); bus.Data_Out = 32'hD00D; bus.AA = 5'd7; bus.BA = 5'd0;
    push("r7_bypass", K_A, 32'h1); push("r0_b", K_B, 32'h0);
    cycle();
    idle(); wr(5'd8, 2'b11, 32'h8888); bus.AA = 5'd7; bus.BA = 5'd8;
    push("r7_stored", K_A, 32'h1); push("r8_dout_bypass", K_B, 32'hD00D);
    cycle();
    idle(); bus.BA = 5'd8;
    push("r8_newest_bypass", K_B, 32'h8888);
    cycle();
    idle(); bus.AA = 5'd8;
    push("r8_stored", K_A, 32'h8888);
    cycle();

    // reset one cycle after a taken branch with a write pending
    idle(); br(2'b10, 1'b0, 1'b0, 32'h20, 32'h0); wr(5'd9, 2'b00, 32'h99);
    exp_pc("pre_rst_tk", 1'b1, 2'b01, 32'h20);
    cycle();
    idle(); RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    idle(); bus.AA = 5'd5; bus.BA = 5'd9;
    br(2'b10, 1'b0, 1'b0, 32'h30, 32'h0); wr(5'd10, 2'b00, 32'hAAAA);
    push("post_rst_r5", K_A, 32'h0); push("post_rst_r9", K_B, 32'h0);
    exp_pc("post_rst_tk", 1'b1, 2'b01, 32'h30);
    cycle();
    idle(); bus.AA = 5'd10;
    push("r10_bypass", K_A, 32'hAAAA);
    cycle();
    idle(); bus.AA = 5'd10;
    push("r10_stored", K_A, 32'hAAAA);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
